xdma_usr_irq_ctrl: RTL and testbench

Parametrised XDMA user-interrupt controller: up to `N_CH` sticky interrupt channels, each raised by a one-cycle completion pulse from a datapath engine (IM/RTM/XPHM/CWM/BM loaders, exec done, …). Each channel drives its `usr_irq_req` bit with a full XDMA req/ack handshake. Channels support host masking, re-arm of events that arrive during service, and sticky overflow reporting. The block sits between the engine done-pulses and the XDMA IP user-IRQ port; its status/mask registers are exposed through the AXI-Lite register file.

---
 rtl/xdma_usr_irq_ctrl_pkg.sv | 27 ++
 rtl/xdma_usr_irq_ctrl_if.sv | 22 ++
 rtl/xdma_usr_irq_ctrl_ch.sv | 80 ++++++++
 rtl/xdma_usr_irq_ctrl.sv | 65 ++++++
 tb/tb_xdma_usr_irq_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xdma_usr_irq_ctrl_pkg.sv
// Shared constants and types for the XDMA user-interrupt controller.
// Channel map, FSM encodings and the per-channel input bundle.
package xdma_usr_irq_ctrl_pkg;

    localparam int XDMA_USR_INTR_COUNT = 7;

    localparam int CH_IM_D2C   = 0;
    localparam int CH_RTM_D2C  = 1;
    localparam int CH_RTM_C2D  = 2;
    localparam int CH_XPHM_D2C = 3;
    localparam int CH_CWM_D2C  = 4;
    localparam int CH_BM_D2C   = 5;
    localparam int CH_EXEC     = 6;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSERT   = 2'd1;
    localparam logic [1:0] ST_SERVICED = 2'd2;
    localparam logic [1:0] ST_DEASSERT = 2'd3;

    typedef struct packed {
        logic evt;
        logic clr;
        logic ack;
        logic masked;
    } ch_in_t;

endpackage

// File: rtl/xdma_usr_irq_ctrl_if.sv
// XDMA user-IRQ req/ack port bundle.
// master = interrupt controller, slave = XDMA IP.
interface xdma_usr_irq_ctrl_if
    import xdma_usr_irq_ctrl_pkg::*;
#(
    parameter int N_CH = XDMA_USR_INTR_COUNT
);

    logic [N_CH-1:0] usr_irq_req;
    logic [N_CH-1:0] usr_irq_ack;

    modport master (
        output usr_irq_req,
        input  usr_irq_ack
    );

    modport slave (
        input  usr_irq_req,
        output usr_irq_ack
    );

endinterface

// File: rtl/xdma_usr_irq_ctrl_ch.sv
// One sticky user-interrupt channel: req/ack FSM, re-arm and overflow.
// Optional saturating event counter under XDMA_USR_IRQ_CNT_EN.
module xdma_usr_irq_ch
    import xdma_usr_irq_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  ch_in_t           ci,
    output logic             req,
    output logic             pend,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);

    logic [1:0] st;
    logic       rearm;
    logic       raise;

    assign raise = (ci.evt | rearm) & ~ci.masked;
    assign req   = (st == ST_ASSERT) | (st == ST_SERVICED);
    assign pend  = (st != ST_IDLE) | rearm;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            st    <= ST_IDLE;
            rearm <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (raise) begin
                        st    <= ST_ASSERT;
                        rearm <= 1'b0;
                    end else if (ci.evt) begin
                        rearm <= 1'b1;
                    end
                    // A fresh event on top of a pending re-arm is lost.
                    if (ci.evt & rearm)
                        ovf <= 1'b1;
                    else if (ci.clr)
                        ovf <= 1'b0;
                end
                ST_ASSERT: begin
                    if (ci.clr)
                        st <= ST_DEASSERT;
                    else if (ci.ack)
                        st <= ST_SERVICED;
                end
                ST_SERVICED: begin
                    if (ci.clr)
                        st <= ST_DEASSERT;
                end
                ST_DEASSERT: begin
                    if (ci.ack)
                        st <= ST_IDLE;
                end
            endcase
            if ((st != ST_IDLE) && ci.evt) begin
                if (rearm)
                    ovf <= 1'b1;
                else
                    rearm <= 1'b1;
            end
        end
    end

`ifdef XDMA_USR_IRQ_CNT_EN
    always_ff @(posedge clk) begin
        if (sys_rst)
            cnt <= '0;
        else if (ci.evt && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end
`else
    assign cnt = '0;
`endif

endmodule

// File: rtl/xdma_usr_irq_ctrl.sv
// XDMA user-interrupt controller: mask register plus N_CH channels.
// XDMA_USR_IRQ_CNT_EN adds event counters and a masked reset state.
module xdma_usr_irq_ctrl
    import xdma_usr_irq_ctrl_pkg::*;
#(
    parameter int N_CH  = XDMA_USR_INTR_COUNT,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [N_CH-1:0]       evt_pulse,
    input  logic [N_CH-1:0]       intr_clr,
    input  logic [N_CH-1:0]       intr_clr_vld,
    input  logic [N_CH-1:0]       mask_wdata,
    input  logic                  mask_wr,
    xdma_usr_irq_ctrl_if.master   xdma,
    output logic [N_CH-1:0]       irq_mask,
    output logic [N_CH-1:0]       irq_pend,
    output logic [N_CH-1:0]       irq_ovf,
    output logic [N_CH*CNT_W-1:0] evt_cnt
);

`ifdef XDMA_USR_IRQ_CNT_EN
    localparam logic MASK_RST = 1'b1;
`else
    localparam logic MASK_RST = 1'b0;
`endif

    logic [N_CH-1:0] mask_eff;
    logic [N_CH-1:0] req_v;

    always_ff @(posedge clk) begin
        if (sys_rst)
            irq_mask <= {N_CH{MASK_RST}};
        else if (mask_wr)
            irq_mask <= mask_wdata;
    end

    // Bypass the write so an unmask raises a re-armed channel next cycle.
    assign mask_eff = mask_wr ? mask_wdata : irq_mask;

    assign xdma.usr_irq_req = req_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_in_t ci;

        assign ci.evt    = evt_pulse[i];
        assign ci.clr    = intr_clr[i] & intr_clr_vld[i];
        assign ci.ack    = xdma.usr_irq_ack[i];
        assign ci.masked = mask_eff[i];

        xdma_usr_irq_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .sys_rst (sys_rst),
            .ci      (ci),
            .req     (req_v[i]),
            .pend    (irq_pend[i]),
            .ovf     (irq_ovf[i]),
            .cnt     (evt_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_xdma_usr_irq_ctrl.sv
// Scoreboard bench for xdma_usr_irq_ctrl (7 channels, 16-bit counters).
// Builds with or without XDMA_USR_IRQ_CNT_EN.
module tb_xdma_usr_irq_ctrl;
    import xdma_usr_irq_ctrl_pkg::*;

    localparam int N  = 7;
    localparam int CW = 16;

`ifdef XDMA_USR_IRQ_CNT_EN
    localparam logic [N-1:0] MASK_RST = 7'h7F;
    localparam logic         CNT_ON   = 1'b1;
`else
    localparam logic [N-1:0] MASK_RST = 7'h00;
    localparam logic         CNT_ON   = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            sys_rst;
    logic [N-1:0]    evt_pulse;
    logic [N-1:0]    intr_clr;
    logic [N-1:0]    intr_clr_vld;
    logic [N-1:0]    mask_wdata;
    logic            mask_wr;
    logic [N-1:0]    irq_mask;
    logic [N-1:0]    irq_pend;
    logic [N-1:0]    irq_ovf;
    logic [N*CW-1:0] evt_cnt;

    xdma_usr_irq_ctrl_if #(.N_CH(N)) xif ();

    xdma_usr_irq_ctrl #(
        .N_CH  (N),
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .evt_pulse    (evt_pulse),
        .intr_clr     (intr_clr),
        .intr_clr_vld (intr_clr_vld),
        .mask_wdata   (mask_wdata),
        .mask_wr      (mask_wr),
        .xdma         (xif),
        .irq_mask     (irq_mask),
        .irq_pend     (irq_pend),
        .irq_ovf      (irq_ovf),
        .evt_cnt      (evt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] evt;
        logic [N-1:0] clr;
        logic [N-1:0] vld;
        logic [N-1:0] ack;
        logic         mwr;
        logic [N-1:0] md;
        logic [N-1:0] req;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } row_t;

    typedef struct {
        string        tag;
        int           idx;
        logic [N-1:0] req;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    // Apply one cycle of stimulus, queue its expected result, cross the edge.
    task automatic drive(input row_t r, input string tag, input int idx);
        exp_t e;
        evt_pulse        = r.evt;
        intr_clr         = r.clr;
        intr_clr_vld     = r.vld;
        xif.usr_irq_ack  = r.ack;
        mask_wr          = r.mwr;
        mask_wdata       = r.md;
        e.tag  = tag;
        e.idx  = idx;
        e.req  = r.req;
        e.pend = r.pend;
        e.ovf  = r.ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        evt_pulse       = '0;
        intr_clr        = '0;
        intr_clr_vld    = '0;
        xif.usr_irq_ack = '0;
        mask_wr         = 1'b0;
        mask_wdata      = '0;
    endtask

    task automatic test_reset();
        row_t r = '{7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 7'h00,
                    7'h00, 7'h00, 7'h00};
        exp_t e;
        sys_rst = 1'b1;
        zero_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({xif.usr_irq_req, irq_pend, irq_ovf} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_status req/pend/ovf got %h/%h/%h want 0/0/0",
                     xif.usr_irq_req, irq_pend, irq_ovf);
        end
        n_run++;
        if (irq_mask !== MASK_RST) begin
            n_fail++;
            $display("FAIL reset_mask got %h want %h", irq_mask, MASK_RST);
        end
        n_run++;
        if (evt_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt got %h want 0", evt_cnt);
        end
        sys_rst = 1'b0;
        drive(r, "unmask", 0);
        e = sb_q.pop_front();
        n_run++;
        if (irq_mask !== 7'h00 || {xif.usr_irq_req, irq_pend} !== {e.req, e.pend}) begin
            n_fail++;
            $display("FAIL %s mask/req/pend got %h/%h/%h want 00/%h/%h",
                     e.tag, irq_mask, xif.usr_irq_req, irq_pend, e.req, e.pend);
        end
    endtask

    task automatic test_basic();
        row_t rows [6] = '{
            '{7'h01, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h01, 7'h01, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h01, 7'h01, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h01, 1'b0, 7'h00, 7'h01, 7'h01, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h01, 7'h01, 7'h00},
            '{7'h00, 7'h01, 7'h01, 7'h00, 1'b0, 7'h00, 7'h00, 7'h01, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h01, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00}
        };
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i], "basic", i);
            e = sb_q.pop_front();
            n_run++;
            if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
                n_fail++;
                $display("FAIL %s[%0d] req/pend/ovf got %h/%h/%h want %h/%h/%h",
                         e.tag, e.idx, xif.usr_irq_req, irq_pend, irq_ovf,
                         e.req, e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_mask();
        row_t rows [7] = '{
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 7'h08, 7'h00, 7'h00, 7'h00},
            '{7'h08, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h00, 7'h08, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h00, 7'h08, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 7'h00, 7'h08, 7'h08, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h08, 1'b0, 7'h00, 7'h08, 7'h08, 7'h00},
            '{7'h00, 7'h08, 7'h08, 7'h00, 1'b0, 7'h00, 7'h00, 7'h08, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h08, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00}
        };
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i], "mask", i);
            e = sb_q.pop_front();
            n_run++;
            if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
                n_fail++;
                $display("FAIL %s[%0d] req/pend/ovf got %h/%h/%h want %h/%h/%h",
                         e.tag, e.idx, xif.usr_irq_req, irq_pend, irq_ovf,
                         e.req, e.pend, e.ovf);
            end
            if (i == 0) begin
                n_run++;
                if (irq_mask !== 7'h08) begin
                    n_fail++;
                    $display("FAIL mask_reg got %h want 08", irq_mask);
                end
            end
        end
    endtask

    task automatic test_overflow();
        row_t rows [12] = '{
            '{7'h04, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h04, 7'h04, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h04, 1'b0, 7'h00, 7'h04, 7'h04, 7'h00},
            '{7'h04, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h04, 7'h04, 7'h00},
            '{7'h04, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h04, 7'h04, 7'h04},
            '{7'h04, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h04, 7'h04, 7'h04},
            '{7'h00, 7'h04, 7'h04, 7'h00, 1'b0, 7'h00, 7'h00, 7'h04, 7'h04},
            '{7'h00, 7'h00, 7'h00, 7'h04, 1'b0, 7'h00, 7'h00, 7'h04, 7'h04},
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h04, 7'h04, 7'h04},
            '{7'h00, 7'h00, 7'h00, 7'h04, 1'b0, 7'h00, 7'h04, 7'h04, 7'h04},
            '{7'h00, 7'h04, 7'h04, 7'h00, 1'b0, 7'h00, 7'h00, 7'h04, 7'h04},
            '{7'h00, 7'h00, 7'h00, 7'h04, 1'b0, 7'h00, 7'h00, 7'h00, 7'h04},
            '{7'h00, 7'h04, 7'h04, 7'h00, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00}
        };
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i], "overflow", i);
            e = sb_q.pop_front();
            n_run++;
            if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
                n_fail++;
                $display("FAIL %s[%0d] req/pend/ovf got %h/%h/%h want %h/%h/%h",
                         e.tag, e.idx, xif.usr_irq_req, irq_pend, irq_ovf,
                         e.req, e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_all_channels();
        row_t rows [5] = '{
            '{7'h7F, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h7F, 7'h7F, 7'h00},
            '{7'h00, 7'h20, 7'h20, 7'h00, 1'b0, 7'h00, 7'h5F, 7'h7F, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h7F, 1'b0, 7'h00, 7'h5F, 7'h5F, 7'h00},
            '{7'h00, 7'h5F, 7'h5F, 7'h00, 1'b0, 7'h00, 7'h00, 7'h5F, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h5F, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00}
        };
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i], "all_ch", i);
            e = sb_q.pop_front();
            n_run++;
            if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
                n_fail++;
                $display("FAIL %s[%0d] req/pend/ovf got %h/%h/%h want %h/%h/%h",
                         e.tag, e.idx, xif.usr_irq_req, irq_pend, irq_ovf,
                         e.req, e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_clr_qual();
        row_t rows [5] = '{
            '{7'h02, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h02, 7'h02, 7'h00},
            '{7'h00, 7'h02, 7'h00, 7'h00, 1'b0, 7'h00, 7'h02, 7'h02, 7'h00},
            '{7'h00, 7'h00, 7'h02, 7'h00, 1'b0, 7'h00, 7'h02, 7'h02, 7'h00},
            '{7'h00, 7'h02, 7'h02, 7'h02, 1'b0, 7'h00, 7'h00, 7'h02, 7'h00},
            '{7'h00, 7'h00, 7'h00, 7'h02, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00}
        };
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i], "clr_qual", i);
            e = sb_q.pop_front();
            n_run++;
            if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
                n_fail++;
                $display("FAIL %s[%0d] req/pend/ovf got %h/%h/%h want %h/%h/%h",
                         e.tag, e.idx, xif.usr_irq_req, irq_pend, irq_ovf,
                         e.req, e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows [8] = '{
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 7'h10, 7'h00, 7'h00, 7'h00},
            '{7'h10, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h00, 7'h10, 7'h00},
            '{7'h10, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00, 7'h00, 7'h10, 7'h10},
            '{7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 7'h00, 7'h10, 7'h10, 7'h10},
            '{7'h00, 7'h00, 7'h00, 7'h10, 1'b0, 7'h00, 7'h10, 7'h10, 7'h10},
            '{7'h00, 7'h10, 7'h10, 7'h00, 1'b0, 7'h00, 7'h00, 7'h10, 7'h10},
            '{7'h00, 7'h00, 7'h00, 7'h10, 1'b0, 7'h00, 7'h00, 7'h00, 7'h10},
            '{7'h00, 7'h10, 7'h10, 7'h00, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00}
        };
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i], "b2b", i);
            e = sb_q.pop_front();
            n_run++;
            if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
                n_fail++;
                $display("FAIL %s[%0d] req/pend/ovf got %h/%h/%h want %h/%h/%h",
                         e.tag, e.idx, xif.usr_irq_req, irq_pend, irq_ovf,
                         e.req, e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_rst_mid();
        row_t r0 = '{7'h7F, 7'h00, 7'h00, 7'h00, 1'b0, 7'h00,
                     7'h7F, 7'h7F, 7'h00};
        row_t r1 = '{7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 7'h00,
                     7'h00, 7'h00, 7'h00};
        exp_t e;
        drive(r0, "rst_mid_raise", 0);
        e = sb_q.pop_front();
        n_run++;
        if ({xif.usr_irq_req, irq_pend, irq_ovf} !== {e.req, e.pend, e.ovf}) begin
            n_fail++;
            $display("FAIL %s req/pend/ovf got %h/%h/%h want %h/%h/%h",
                     e.tag, xif.usr_irq_req, irq_pend, irq_ovf,
                     e.req, e.pend, e.ovf);
        end
        zero_inputs();
        sys_rst = 1'b1;
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        n_run++;
        if ({xif.usr_irq_req, irq_pend, irq_ovf} !== 21'h0 ||
            irq_mask !== MASK_RST || evt_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_mid req/pend/ovf/mask/cnt got %h/%h/%h/%h/%h want 0/0/0/%h/0",
                     xif.usr_irq_req, irq_pend, irq_ovf, irq_mask, evt_cnt, MASK_RST);
        end
        drive(r1, "rst_mid_unmask", 1);
        e = sb_q.pop_front();
        n_run++;
        if ({xif.usr_irq_req, irq_pend, irq_mask} !== {e.req, e.pend, 7'h00}) begin
            n_fail++;
            $display("FAIL %s req/pend/mask got %h/%h/%h want %h/%h/00",
                     e.tag, xif.usr_irq_req, irq_pend, irq_mask, e.req, e.pend);
        end
    endtask

    task automatic test_counter();
        logic [CW-1:0] c6;
        logic [CW-1:0] c0;
        zero_inputs();
        evt_pulse = 7'h40;
        repeat (5) @(posedge clk);
        #1;
        c6 = evt_cnt[CH_EXEC*CW +: CW];
        n_run++;
        if (c6 !== (CNT_ON ? 16'd5 : 16'd0)) begin
            n_fail++;
            $display("FAIL cnt_partial ch6 got %0d want %0d", c6, CNT_ON ? 5 : 0);
        end
        repeat (69995) @(posedge clk);
        #1;
        evt_pulse = '0;
        c6 = evt_cnt[CH_EXEC*CW +: CW];
        c0 = evt_cnt[CH_IM_D2C*CW +: CW];
        n_run++;
        if (c6 !== (CNT_ON ? 16'hFFFF : 16'd0)) begin
            n_fail++;
            $display("FAIL cnt_sat ch6 got %0d want %0d", c6, CNT_ON ? 65535 : 0);
        end
        n_run++;
        if (c0 !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_other ch0 got %0d want 0", c0);
        end
        n_run++;
        if (irq_ovf[CH_EXEC] !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_ovf ch6 got %b want 1", irq_ovf[CH_EXEC]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_overflow();
        test_all_channels();
        test_clr_qual();
        test_back_to_back();
        test_rst_mid();
        test_counter();
        n_run++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
